dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single DRAM port (Dram::WIDTH-bit data, burst-capable, waitrequest-style) between NUM_REQ requesters.
- Typical requesters: the layer-IO reader tiler, the layer-IO writer tiler and the weight reader.
- Each requester issues a burst command; grants rotate round-robin and each burst is atomic.
- Read data is steered back only to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters.
- ADDR_WIDTH, $clog2(Dram::DEPTH), DRAM word address width.
- DATA_WIDTH, Dram::WIDTH (576), beat width.
- BURST_WIDTH, 7, burst-length field width; legal lengths are 1..64.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  command accepted (one-hot, at most one bit set).
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr  in  NUM_REQ x ADDR_WIDTH  burst start address.
- req_burst  in  NUM_REQ x BURST_WIDTH  burst length; 0 is treated as 1.
- wr_valid  in  NUM_REQ  write beat valid.
- wr_data  in  NUM_REQ x DATA_WIDTH  write beat data.
- wr_ready  out  NUM_REQ  write beat accepted.
- rd_valid  out  NUM_REQ  read beat valid, one-hot to owner.
- rd_data  out  DATA_WIDTH  read beat data, broadcast to all requesters.
- dram_address  out  ADDR_WIDTH  registered burst address.
- dram_burstcount  out  BURST_WIDTH  registered burst length.
- dram_read  out  1  read command.
- dram_write  out  1  write beat strobe.
- dram_writedata  out  DATA_WIDTH  write beat data.
- dram_waitrequest  in  1  DRAM stall.
- dram_readdata  in  DATA_WIDTH  DRAM return data.
- dram_readdatavalid  in  1  DRAM return valid.
- busy  out  1  state != IDLE.
- owner  out  $clog2(NUM_REQ)  current/last grantee.

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - state = IDLE, rr_ptr = 0, owner = 0.
  - All valid/strobe/ready outputs are 0; dram_address, dram_burstcount and the data outputs are 0.
  - Beat counters are cleared.
- IDLE:
  - Winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle.
  - Winner's write flag, address and burst are registered; owner = winner.
  - Next state: RD_CMD if read, WR_DATA if write.
  - No req_valid set: stay in IDLE, all req_ready = 0.
- RD_CMD:
  - dram_read = 1 with registered address/burstcount; held until a cycle with dram_waitrequest = 0, then go to RD_DATA.
  - Command-to-DRAM latency is 1 cycle after the req handshake.
- RD_DATA:
  - Each dram_readdatavalid produces rd_valid[owner] = 1 and rd_data = dram_readdata in the same cycle (combinational path, no buffering).
  - Requesters must sink every beat; there is no backpressure.
  - A beat counter counts beats; when it reaches burst, go to IDLE next cycle.
  - A readdatavalid arriving in RD_CMD (before command acceptance) is ignored.
- WR_DATA:
  - dram_write = wr_valid[owner]; dram_writedata = wr_data[owner].
  - wr_ready[owner] = !dram_waitrequest; all other wr_ready = 0.
  - Address and burstcount are held constant for the whole burst.
  - A beat is accepted when dram_write && !dram_waitrequest.
  - After the burst-th beat, go to IDLE.
- Leaving a burst (RD_DATA or WR_DATA to IDLE):
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Arbitration resumes in the IDLE cycle, so back-to-back bursts have a 1-cycle bubble.
- Non-owner signals: req_valid from non-owners is held pending and never dropped; wr_valid from non-owners is ignored.
- readdatavalid in IDLE or WR_DATA (stale data after a reset mid-read) is ignored; rd_valid stays 0.
- Reset mid-burst abandons the burst immediately. Recovering the DRAM controller and the requesters is the caller's job.
- Burst 0 is treated as 1 in every counter and on dram_burstcount.

Test Plan:
- Single read: req 0, addr 0x100, burst 4; waitrequest low; DRAM returns 4 beats 2 cycles later.
  - dram_read high exactly 1 cycle after req_ready[0].
  - rd_valid = 3'b001 for 4 beats; busy falls the cycle after the last beat.
- Write with stalls: req 1, addr 0x20, burst 3; waitrequest high on the 2nd beat for 2 cycles.
  - Exactly 3 accepted beats; data order preserved.
  - wr_ready[1] low during the stall; address 0x20 held throughout.
- Round-robin, all three requesting reads of burst 1 continuously from reset:
  - Grant order 0,1,2,0,1,2.
  - Second grant occurs 1 idle cycle after the first burst completes.
- RD_CMD stall: waitrequest high for 5 cycles.
  - dram_read held high with stable address for 6 cycles; no rd_valid.
- Burst 0: req 2 write, burst 0.
  - dram_burstcount = 1; one beat accepted; returns to IDLE.
- Reset mid-burst: resetn low during RD_DATA after 2 of 8 beats; then 6 stale readdatavalid after release.
  - All outputs 0 immediately on reset.
  - No rd_valid for the stale beats; next grant goes to requester 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one burst-capable, waitrequest-style DRAM port between
// NUM_REQ requesters. Grants rotate round-robin, each burst runs to completion
// once granted, and read beats are steered back only to the burst owner.
module dram_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_WIDTH  = 16,   // $clog2 of the DRAM depth
    parameter int DATA_WIDTH  = 576,  // DRAM beat width
    parameter int BURST_WIDTH = 7     // legal burst lengths 1..64, 0 means 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*BURST_WIDTH-1:0]  req_burst,
    input  logic [NUM_REQ-1:0]              wr_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]              wr_ready,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ADDR_WIDTH-1:0]           dram_address,
    output logic [BURST_WIDTH-1:0]          dram_burstcount,
    output logic                            dram_read,
    output logic                            dram_write,
    output logic [DATA_WIDTH-1:0]           dram_writedata,
    input  logic                            dram_waitrequest,
    input  logic [DATA_WIDTH-1:0]           dram_readdata,
    input  logic                            dram_readdatavalid,
    output logic                            busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t                 state_r;
    logic [OW-1:0]          rr_ptr_r;
    logic [OW-1:0]          owner_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [BURST_WIDTH-1:0] burst_r;
    logic [BURST_WIDTH-1:0] beat_r;

    logic                   grant_s;
    logic [OW-1:0]          winner_s;
    logic [OW-1:0]          next_ptr_s;
    logic [ADDR_WIDTH-1:0]  win_addr_s;
    logic [BURST_WIDTH-1:0] win_burst_s;
    logic                   last_beat_s;
    logic                   wr_accept_s;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        int idx;
        logic hit;
        idx      = 0;
        hit      = 1'b0;
        grant_s  = 1'b0;
        winner_s = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx      = (int'(rr_ptr_r) + k) % NUM_REQ;
            hit      = req_valid[idx] && !grant_s;
            winner_s = hit ? OW'(idx) : winner_s;
            grant_s  = grant_s | hit;
        end
        win_addr_s  = req_addr[int'(winner_s)*ADDR_WIDTH +: ADDR_WIDTH];
        win_burst_s = req_burst[int'(winner_s)*BURST_WIDTH +: BURST_WIDTH];
        // A zero-length burst is carried as a single beat everywhere.
        win_burst_s = (win_burst_s == '0) ? BURST_WIDTH'(1) : win_burst_s;
    end

    // Command handshake: only the winner sees ready, and only while idle.
    always_comb begin
        req_ready = '0;
        if (state_r == IDLE && grant_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Data-path steering between the owner and the DRAM port.
    always_comb begin
        rd_valid       = '0;
        rd_data        = '0;
        wr_ready       = '0;
        dram_write     = 1'b0;
        dram_writedata = '0;
        case (state_r)
            RD_DATA: begin
                if (dram_readdatavalid) begin
                    rd_valid[owner_r] = 1'b1;
                    rd_data           = dram_readdata;
                end else begin
                    rd_valid = '0;
                end
            end
            WR_DATA: begin
                dram_write        = wr_valid[owner_r];
                dram_writedata    = wr_data[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
                wr_ready[owner_r] = !dram_waitrequest;
            end
            default: begin
                rd_valid = '0;
            end
        endcase
    end

    assign wr_accept_s = dram_write && !dram_waitrequest;
    assign last_beat_s = (beat_r + BURST_WIDTH'(1)) == burst_r;
    assign next_ptr_s  = (owner_r == OW'(NUM_REQ - 1)) ? '0 : owner_r + OW'(1);

    // Burst FSM: latches the granted command and counts beats until the burst ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            addr_r   <= '0;
            burst_r  <= '0;
            beat_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_r <= winner_s;
                        addr_r  <= win_addr_s;
                        burst_r <= win_burst_s;
                        beat_r  <= '0;
                        state_r <= req_write[winner_s] ? WR_DATA : RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (!dram_waitrequest) begin
                        state_r <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (dram_readdatavalid) begin
                        if (last_beat_s) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_ptr_s;
                            beat_r   <= '0;
                        end else begin
                            beat_r <= beat_r + BURST_WIDTH'(1);
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_accept_s) begin
                        if (last_beat_s) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_ptr_s;
                            beat_r   <= '0;
                        end else begin
                            beat_r <= beat_r + BURST_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dram_address    = addr_r;
    assign dram_burstcount = burst_r;
    assign dram_read       = (state_r == RD_CMD);
    assign busy            = (state_r != IDLE);
    assign owner           = owner_r;

endmodule
